// File: rtl/imem_fetch.sv
// Instruction-fetch stage: owns the PC, drives the ROM address, registers the
// fetched word into IF/ID, and latches a sticky fault on illegal fetch addresses.
module imem_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [23:0] ROM_BASE = 24'd0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        fault,
  output logic [31:0] fetch_count
);

  typedef enum logic {RUN, FAULT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt, pc4;
  logic        bad_pc, advance, bubble;

  assign pc4       = pc + 32'd4;
  assign bad_pc    = (pc[1:0] != 2'b00) || (pc[31:8] != ROM_BASE);
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == RUN && bad_pc) state_nxt = FAULT;
  end

  // The fault check outranks redirects: a bad pc is never fetched or replaced.
  always_comb begin
    pc_nxt  = pc;
    advance = 1'b0;
    bubble  = 1'b0;
    case (state)
      RUN: begin
        if (bad_pc) begin
          bubble = 1'b1;
        end else if (branch_taken) begin
          pc_nxt = branch_target;
          bubble = 1'b1;
        end else if (jump) begin
          pc_nxt = jump_target;
          bubble = 1'b1;
        end else if (!stall) begin
          pc_nxt  = pc4;
          advance = 1'b1;
        end
      end
      default: bubble = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      ifid_instr  <= '0;
      ifid_pc4    <= '0;
      ifid_valid  <= 1'b0;
      fault       <= 1'b0;
      fetch_count <= '0;
    end else begin
      pc    <= pc_nxt;
      fault <= (state_nxt == FAULT);
      if (bubble) begin
        ifid_instr <= '0;
        ifid_pc4   <= '0;
        ifid_valid <= 1'b0;
      end else if (advance) begin
        ifid_instr  <= imem_data;
        ifid_pc4    <= pc4;
        ifid_valid  <= 1'b1;
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch.sv
// Directed bench for imem_fetch: the driver queues the expected post-edge state,
// a negedge monitor pops and compares it against the DUT outputs.
module tb_imem_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, imem_data;
  logic        stall, branch_taken, jump;
  logic [31:0] branch_target, jump_target;
  logic [31:0] ifid_instr, ifid_pc4, fetch_count;
  logic        ifid_valid, fault;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        flt;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  imem_fetch dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .ifid_instr(ifid_instr),
    .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid), .fault(fault),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'd0) return 32'h8c02_0004;
    return {16'hC0DE, a[15:0]};
  endfunction

  always_comb imem_data = rom(imem_addr);

  // Apply inputs for the next edge, then queue the state expected after it.
  task automatic step(input string nm, input logic rst, input logic st,
                      input logic bt, input logic [31:0] btgt,
                      input logic jp, input logic [31:0] jtgt,
                      input logic [31:0] e_addr, input logic [31:0] e_instr,
                      input logic [31:0] e_pc4, input logic e_v, input logic e_f,
                      input logic [31:0] e_cnt);
    exp_t e;
    reset = rst; stall = st; branch_taken = bt; branch_target = btgt;
    jump = jp; jump_target = jtgt;
    @(posedge clk);
    e.name = nm; e.addr = e_addr; e.instr = e_instr; e.pc4 = e_pc4;
    e.valid = e_v; e.flt = e_f; e.cnt = e_cnt;
    q.push_back(e);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++;
        if (imem_addr !== e.addr || ifid_instr !== e.instr || ifid_pc4 !== e.pc4 ||
            ifid_valid !== e.valid || fault !== e.flt || fetch_count !== e.cnt) begin
          fails++;
          $display("FAIL %s: got addr=%h instr=%h pc4=%h v=%b f=%b cnt=%0d, want addr=%h instr=%h pc4=%h v=%b f=%b cnt=%0d",
                   e.name, imem_addr, ifid_instr, ifid_pc4, ifid_valid, fault, fetch_count,
                   e.addr, e.instr, e.pc4, e.valid, e.flt, e.cnt);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_target = '0; jump_target = '0;

    step("reset",      1, 0, 0, 0, 0, 0,  32'd0,  32'h0,         32'd0,  0, 0, 0);
    step("run_e1",     0, 0, 0, 0, 0, 0,  32'd4,  32'h8c02_0004, 32'd4,  1, 0, 1);
    step("run_e2",     0, 0, 0, 0, 0, 0,  32'd8,  32'hC0DE_0004, 32'd8,  1, 0, 2);
    for (int i = 0; i < 3; i++)
      step("stall_pc8",0, 1, 0, 0, 0, 0,  32'd8,  32'hC0DE_0004, 32'd8,  1, 0, 2);
    step("resume_e3",  0, 0, 0, 0, 0, 0,  32'd12, 32'hC0DE_0008, 32'd12, 1, 0, 3);
    step("run_e4",     0, 0, 0, 0, 0, 0,  32'd16, 32'hC0DE_000C, 32'd16, 1, 0, 4);
    step("run_to20",   0, 0, 0, 0, 0, 0,  32'd20, 32'hC0DE_0010, 32'd20, 1, 0, 5);
    step("run_to24",   0, 0, 0, 0, 0, 0,  32'd24, 32'hC0DE_0014, 32'd24, 1, 0, 6);
    step("run_to28",   0, 0, 0, 0, 0, 0,  32'd28, 32'hC0DE_0018, 32'd28, 1, 0, 7);
    step("run_to32",   0, 0, 0, 0, 0, 0,  32'd32, 32'hC0DE_001C, 32'd32, 1, 0, 8);
    step("run_to36",   0, 0, 0, 0, 0, 0,  32'd36, 32'hC0DE_0020, 32'd36, 1, 0, 9);
    step("jump56",     0, 0, 0, 0, 1, 56, 32'd56, 32'h0,         32'd0,  0, 0, 9);
    step("jump_tgt",   0, 0, 0, 0, 0, 0,  32'd60, 32'hC0DE_0038, 32'd60, 1, 0, 10);
    step("br_and_jmp", 0, 0, 1, 16, 1, 56, 32'd16, 32'h0,        32'd0,  0, 0, 10);
    step("br_tgt",     0, 0, 0, 0, 0, 0,  32'd20, 32'hC0DE_0010, 32'd20, 1, 0, 11);
    step("br_over_st", 0, 1, 1, 40, 0, 0, 32'd40, 32'h0,         32'd0,  0, 0, 11);
    step("stall_bub",  0, 1, 0, 0, 0, 0,  32'd40, 32'h0,         32'd0,  0, 0, 11);
    step("br40_tgt",   0, 0, 0, 0, 0, 0,  32'd44, 32'hC0DE_0028, 32'd44, 1, 0, 12);
    step("br_unalign", 0, 0, 1, 32'h102, 0, 0, 32'h102, 32'h0,   32'd0,  0, 0, 12);
    step("fault_set",  0, 0, 0, 0, 0, 0,  32'h102, 32'h0,        32'd0,  0, 1, 12);
    step("fault_redir",0, 0, 1, 0, 1, 8,  32'h102, 32'h0,        32'd0,  0, 1, 12);
    step("fault_hold", 0, 0, 0, 0, 0, 0,  32'h102, 32'h0,        32'd0,  0, 1, 12);
    step("reset_mid",  1, 0, 0, 0, 0, 0,  32'd0,  32'h0,         32'd0,  0, 0, 0);
    // Sequential run from 0 up to 0x100, the first address outside the window.
    for (int k = 1; k <= 64; k++)
      step("seq_run",  0, 0, 0, 0, 0, 0,  32'(4*k), rom(32'(4*(k-1))), 32'(4*k), 1, 0, 32'(k));
    step("fault_win",  0, 0, 0, 0, 0, 0,  32'h100, 32'h0,        32'd0,  0, 1, 64);
    step("fault_st",   0, 1, 0, 0, 0, 0,  32'h100, 32'h0,        32'd0,  0, 1, 64);
    step("reset_clr",  1, 0, 0, 0, 0, 0,  32'd0,  32'h0,         32'd0,  0, 0, 0);
    step("refetch0",   0, 0, 0, 0, 0, 0,  32'd4,  32'h8c02_0004, 32'd4,  1, 0, 1);

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
